// File: rtl/adc_sample_ctrl.sv
// ============================================================================
// adc_sample_ctrl
// ----------------------------------------------------------------------------
// Digital-side sequencer for the on-chip 8-bit ADC.
//   * Divides the core clock down to adc_clock while an acquisition runs.
//   * Captures adc_data on every falling edge of adc_clock.
//   * Buffers samples in a small FIFO and hands them out over valid/ready.
//
// Optional feature (compile-time macro ADC_SAMPLE_CTRL_AVG_EN):
//   When defined, groups of four captures are summed. One truncating
//   average is pushed per group. The burst counter then counts averages.
//   When undefined, every capture is pushed raw and no accumulator exists.
//
// Ports:
//   clock      in   core clock, all logic on the rising edge
//   reset      in   synchronous reset, active low (0 = reset)
//   start      in   one-cycle pulse, begins an acquisition (IDLE only)
//   stop       in   one-cycle pulse, ends an acquisition (RUN only)
//   cfg_div    in   adc_clock half-period minus 1, latched at start
//   cfg_burst  in   samples to push before stopping, 0 = continuous
//   adc_clock  out  clock to the ADC, low outside RUN
//   adc_data   in   conversion result from the ADC
//   out_valid  out  FIFO non-empty
//   out_data   out  FIFO head (registered)
//   out_ready  in   consumer accept
//   busy       out  FSM not IDLE
//   overflow   out  sticky, a sample was dropped on a full FIFO
//   fifo_level out  current FIFO occupancy
// ============================================================================
module adc_sample_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic [DIV_WIDTH-1:0]        cfg_div,
    input  logic [CNT_WIDTH-1:0]        cfg_burst,
    output logic                        adc_clock,
    input  logic [DATA_WIDTH-1:0]       adc_data,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [DIV_WIDTH-1:0]  r_div_lat;
    logic [CNT_WIDTH-1:0]  r_burst_lat;
    logic [DIV_WIDTH-1:0]  r_div_cnt;
    logic                  r_adc_clk;

    logic                  r_cap_vld;
    logic [DATA_WIDTH-1:0] r_cap_data;
    logic [CNT_WIDTH-1:0]  r_burst_cnt;
    logic                  r_ovf;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [DATA_WIDTH-1:0] r_out_data;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  w_start_run;
    logic                  w_div_tc;
    logic                  w_capture;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push_ok;
    logic [CNT_WIDTH-1:0]  w_burst_cnt_inc;
    logic                  w_burst_done;
    logic [AW-1:0]         w_head_idx;
    logic [LW-1:0]         w_level_next;
    logic [DATA_WIDTH-1:0] w_head_next;

    assign w_start_run = (r_state == ST_IDLE) && start;
    assign w_div_tc    = (r_div_cnt == r_div_lat);

    // A capture is the terminal count while adc_clock is high, i.e. the
    // edge on which adc_clock falls. stop on the same edge wins, so the
    // forced low edge of STOP never produces a sample.
    assign w_capture = (r_state == ST_RUN) && !stop && w_div_tc && r_adc_clk;

    // Saturating increment so a very long continuous run never wraps.
    assign w_burst_cnt_inc = (r_burst_cnt == {CNT_WIDTH{1'b1}}) ?
                             r_burst_cnt : r_burst_cnt + CNT_WIDTH'(1);

    // Dropped samples still count, so this keys off the push request,
    // not the accepted push.
    assign w_burst_done = w_push && (r_burst_lat != '0) &&
                          (w_burst_cnt_inc == r_burst_lat);

    // ------------------------------------------------------------------
    // Push source: raw capture or 4-sample average
    // ------------------------------------------------------------------
`ifdef ADC_SAMPLE_CTRL_AVG_EN
    logic [DATA_WIDTH+1:0] r_acc;
    logic [1:0]            r_acc_cnt;
    logic [DATA_WIDTH+1:0] w_acc_sum;

    assign w_acc_sum   = r_acc + {2'b00, r_cap_data};
    assign w_push      = r_cap_vld && (r_acc_cnt == 2'd3);
    assign w_push_data = DATA_WIDTH'(w_acc_sum >> 2);

    // The accumulator is cleared whenever the FSM idles. A capture still
    // in flight during STOP is folded in, and any partial group is then
    // thrown away before the next acquisition.
    always_ff @(posedge clock) begin
        if (!reset || (r_state == ST_IDLE)) begin
            r_acc     <= '0;
            r_acc_cnt <= 2'd0;
        end else if (r_cap_vld) begin
            if (r_acc_cnt == 2'd3) begin
                r_acc     <= '0;
                r_acc_cnt <= 2'd0;
            end else begin
                r_acc     <= w_acc_sum;
                r_acc_cnt <= r_acc_cnt + 2'd1;
            end
        end
    end
`else
    assign w_push      = r_cap_vld;
    assign w_push_data = r_cap_data;
`endif

    // ------------------------------------------------------------------
    // FSM and clock divider
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_div_lat   <= '0;
            r_burst_lat <= '0;
            r_div_cnt   <= '0;
            r_adc_clk   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_adc_clk <= 1'b0;
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_div_lat   <= cfg_div;
                        r_burst_lat <= cfg_burst;
                        r_div_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop || w_burst_done) begin
                        r_state   <= ST_STOP;
                        r_adc_clk <= 1'b0;
                    end else if (w_div_tc) begin
                        r_div_cnt <= '0;
                        r_adc_clk <= ~r_adc_clk;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
                    end
                end
                ST_STOP: begin
                    r_state   <= ST_IDLE;
                    r_adc_clk <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_adc_clk <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Capture pipeline, burst counter, overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cap_vld   <= 1'b0;
            r_cap_data  <= '0;
            r_burst_cnt <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_cap_vld <= w_capture;
            if (w_capture) begin
                r_cap_data <= adc_data;
            end

            if (w_start_run) begin
                r_burst_cnt <= '0;
            end else if (w_push) begin
                r_burst_cnt <= w_burst_cnt_inc;
            end

            if (w_start_run) begin
                r_ovf <= 1'b0;
            end else if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    assign w_pop     = (r_level != '0) && out_ready;
    assign w_full    = (r_level == LEVEL_FULL);
    // When full, a pop in the same cycle frees the slot being written.
    assign w_push_ok = w_push && (!w_full || w_pop);

    assign w_level_next = r_level + LW'(w_push_ok) - LW'(w_pop);
    assign w_head_idx   = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

    // out_data is a register holding the head after this cycle's push and
    // pop. If the entry being written becomes the head (FIFO was empty or
    // drains to it), bypass the write data so it shows up next cycle.
    assign w_head_next = (w_push_ok && (r_wr_ptr == w_head_idx)) ?
                         w_push_data : r_mem[w_head_idx];

    // Storage array kept free of reset so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (w_push_ok && reset) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_out_data <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_next;
            if (w_level_next != '0) begin
                r_out_data <= w_head_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign adc_clock  = r_adc_clk;
    assign out_valid  = (r_level != '0);
    assign out_data   = r_out_data;
    assign busy       = (r_state != ST_IDLE);
    assign overflow   = r_ovf;
    assign fifo_level = r_level;

endmodule
